// File: rtl/parking_occupancy_counter.sv
// Saturating parking-lot occupancy counter with BCD free-space digits and overflow/underflow pulses.
// Inputs are synchronized and edge-detected; outputs are registered, 2 edges after the first synchronizer edge.
module parking_occupancy_counter #(
  parameter int CAPACITY = 50,
  parameter int CNT_W    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             S,
  input  logic             R,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic [3:0]       free_tens,
  output logic [3:0]       free_units,
  output logic             ovf,
  output logic             unf
);

  localparam logic [3:0]       CAP_TENS  = 4'(CAPACITY / 10);
  localparam logic [3:0]       CAP_UNITS = 4'(CAPACITY % 10);
  localparam logic [CNT_W-1:0] CAP_CNT   = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic s_meta, s_sync, s_prev;
  logic r_meta, r_sync, r_prev;
  logic inc, dec;

  logic [CNT_W-1:0] count_nxt;
  logic [3:0]       tens_nxt, units_nxt;
  logic             ovf_nxt, unf_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_meta <= 1'b0;
      s_sync <= 1'b0;
      s_prev <= 1'b0;
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      s_meta <= S;
      s_sync <= s_meta;
      s_prev <= s_sync;
      r_meta <= R;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  // A held level yields one event: only the synchronized rising edge counts.
  assign inc = s_sync & ~s_prev;
  assign dec = r_sync & ~r_prev;

  always_comb begin
    count_nxt = count;
    tens_nxt  = free_tens;
    units_nxt = free_units;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    if (inc && !dec) begin
      if (full) begin
        ovf_nxt = 1'b1;
      end else begin
        count_nxt = count + ONE;
        if (free_units == 4'd0) begin
          units_nxt = 4'd9;
          tens_nxt  = free_tens - 4'd1;
        end else begin
          units_nxt = free_units - 4'd1;
        end
      end
    end else if (dec && !inc) begin
      if (empty) begin
        unf_nxt = 1'b1;
      end else begin
        count_nxt = count - ONE;
        if (free_units == 4'd9) begin
          units_nxt = 4'd0;
          tens_nxt  = free_tens + 4'd1;
        end else begin
          units_nxt = free_units + 4'd1;
        end
      end
    end
  end

  // Flags come from the next-state count so they never lag count by a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      free_tens  <= CAP_TENS;
      free_units <= CAP_UNITS;
      ovf        <= 1'b0;
      unf        <= 1'b0;
    end else begin
      count      <= count_nxt;
      full       <= (count_nxt == CAP_CNT);
      empty      <= (count_nxt == '0);
      free_tens  <= tens_nxt;
      free_units <= units_nxt;
      ovf        <= ovf_nxt;
      unf        <= unf_nxt;
    end
  end

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Testbench for parking_occupancy_counter: directed scenarios plus random S/R traffic against a behavioural model.
module tb_parking_occupancy_counter;

  localparam int CAP = 50;

  logic       clk;
  logic       rst;
  logic       S, R;
  logic [6:0] count;
  logic       full, empty, ovf, unf;
  logic [3:0] free_tens, free_units;

  parking_occupancy_counter #(.CAPACITY(CAP), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .S(S), .R(R),
    .count(count), .full(full), .empty(empty),
    .free_tens(free_tens), .free_units(free_units),
    .ovf(ovf), .unf(unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int ovf_seen = 0;
  int unf_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: values of S/R seen at the last three clock edges; an event is a 0->1
  // step that has travelled through the two synchronizer stages.
  int m_cnt;
  bit m_ovf, m_unf;
  bit hs[3];
  bit hr[3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_ovf = 0; m_unf = 0;
      for (int i = 0; i < 3; i++) begin hs[i] = 0; hr[i] = 0; end
    end else begin
      bit e_in, e_out;
      e_in  = hs[1] && !hs[2];
      e_out = hr[1] && !hr[2];
      m_ovf = 0; m_unf = 0;
      if (e_in && !e_out) begin
        if (m_cnt == CAP) m_ovf = 1; else m_cnt = m_cnt + 1;
      end else if (e_out && !e_in) begin
        if (m_cnt == 0) m_unf = 1; else m_cnt = m_cnt - 1;
      end
      hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = S;
      hr[2] = hr[1]; hr[1] = hr[0]; hr[0] = R;
    end
  end

  always @(negedge clk) begin
    chk("count", int'(count), m_cnt);
    chk("full", int'(full), int'(m_cnt == CAP));
    chk("empty", int'(empty), int'(m_cnt == 0));
    chk("free_tens", int'(free_tens), (CAP - m_cnt) / 10);
    chk("free_units", int'(free_units), (CAP - m_cnt) % 10);
    chk("ovf", int'(ovf), int'(m_ovf));
    chk("unf", int'(unf), int'(m_unf));
    if (ovf) ovf_seen++;
    if (unf) unf_seen++;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse(input bit do_s, input bit do_r, input int hi);
    @(negedge clk);
    if (do_s) S = 1'b1;
    if (do_r) R = 1'b1;
    idle(hi);
    S = 1'b0; R = 1'b0;
    idle(4);
  endtask

  task automatic check_state(input string tag, input int c, input int t, input int u);
    chk({tag, "_count"}, int'(count), c);
    chk({tag, "_tens"}, int'(free_tens), t);
    chk({tag, "_units"}, int'(free_units), u);
    chk({tag, "_full"}, int'(full), int'(c == CAP));
    chk({tag, "_empty"}, int'(empty), int'(c == 0));
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_state("async_rst", 0, 5, 0);
    chk("async_rst_ovf", int'(ovf), 0);
    chk("async_rst_unf", int'(unf), 0);
  endtask

  initial begin
    int o0, u0;
    S = 1'b0; R = 1'b0; rst = 1'b0;
    #1 rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
    check_state("reset", 0, 5, 0);

    // Held level: exactly one entry, two edges after the first sampling edge.
    @(negedge clk); S = 1'b1;
    @(negedge clk); chk("lat_e1", int'(count), 0);
    @(negedge clk); chk("lat_e2", int'(count), 0);
    @(negedge clk); chk("lat_e3", int'(count), 1);
    idle(2); S = 1'b0;
    idle(5);
    check_state("single", 1, 4, 9);

    for (int i = 0; i < 49; i++) pulse(1, 0, 1);
    check_state("fill", 50, 0, 0);
    o0 = ovf_seen;
    pulse(1, 0, 2);
    check_state("ovf_hold", 50, 0, 0);
    chk("ovf_pulses", ovf_seen - o0, 1);

    o0 = ovf_seen;
    pulse(1, 1, 2);
    check_state("simul_full", 50, 0, 0);
    chk("simul_full_ovf", ovf_seen - o0, 0);

    for (int i = 0; i < 47; i++) pulse(0, 1, 1);
    check_state("drain3", 3, 4, 7);
    u0 = unf_seen;
    pulse(0, 1, 1); chk("drain_2", int'(count), 2);
    pulse(0, 1, 1); chk("drain_1", int'(count), 1);
    pulse(0, 1, 1); chk("drain_0", int'(count), 0);
    chk("drain_no_unf", unf_seen - u0, 0);
    pulse(0, 1, 3);
    check_state("unf_hold", 0, 5, 0);
    chk("unf_pulses", unf_seen - u0, 1);

    u0 = unf_seen;
    pulse(1, 1, 2);
    check_state("simul_empty", 0, 5, 0);
    chk("simul_empty_unf", unf_seen - u0, 0);

    for (int i = 0; i < 40; i++) pulse(1, 0, 1);
    check_state("at40", 40, 1, 0);
    pulse(1, 0, 1);
    check_state("borrow41", 41, 0, 9);
    pulse(0, 1, 1);
    check_state("carry40", 40, 1, 0);

    // Entry in flight when reset hits; S still high at release counts once.
    @(negedge clk); S = 1'b1;
    async_reset();
    idle(3);
    chk("rst_hold_count", int'(count), 0);
    rst = 1'b0;
    idle(2);
    chk("post_rst_early", int'(count), 0);
    idle(6);
    check_state("post_rst", 1, 4, 9);
    S = 1'b0;
    idle(4);
    chk("post_rst_once", int'(count), 1);

    // Random traffic in phases biased toward filling, draining or churning.
    for (int seg = 0; seg < 12; seg++) begin
      int ps, pr;
      case (seg % 3)
        0: begin ps = 50; pr = 5; end
        1: begin ps = 5; pr = 50; end
        default: begin ps = 40; pr = 40; end
      endcase
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 99) < ps) S = ~S;
        if ($urandom_range(0, 99) < pr) R = ~R;
      end
      if (seg == 7) async_reset();
      if (seg == 7) begin idle(2); rst = 1'b0; end
    end
    S = 1'b0; R = 1'b0;
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parking_occupancy_counter.md
# parking_occupancy_counter

Occupancy counter that sits directly downstream of the car entry/exit detection FSM. It consumes that FSM's `S` (car entered) and `R` (car left) outputs and keeps a saturating count of parked cars. It also provides full/empty flags, the number of free spaces as two BCD digits for the lot's display driver, and one-cycle error pulses for impossible events. All outputs are registered.

## Interface

Parameters:
- `CAPACITY`, default 50: number of spaces in the lot. Legal range 1..99.
- `CNT_W`, default 7: width of `count`. Must satisfy 2^CNT_W > CAPACITY.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single system clock. All state changes on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `S`, in, 1: entry request from the detection FSM. Level signal, may be asynchronous to `clk` and may stay high for several cycles.
- `R`, in, 1: exit request from the detection FSM. Same properties as `S`.
- `count`, out, CNT_W: cars currently parked, 0..CAPACITY.
- `full`, out, 1: high when `count == CAPACITY`.
- `empty`, out, 1: high when `count == 0`.
- `free_tens`, out, 4: BCD tens digit of `CAPACITY - count`.
- `free_units`, out, 4: BCD units digit of `CAPACITY - count`.
- `ovf`, out, 1: one-cycle pulse when an entry arrives while full.
- `unf`, out, 1: one-cycle pulse when an exit arrives while empty.

## Operation

- **Input stage.** `S` and `R` each pass through a 2-flop synchronizer (`s_sync`, `r_sync`). A third flop holds the previous synchronized value of each. Internal events are rising edges only:
  - `inc = s_sync & ~s_prev`
  - `dec = r_sync & ~r_prev`
  - A level held high for N cycles produces exactly one event.
- **Update rules**, evaluated once per clock:
  - `inc & ~dec & ~full`: `count + 1`. Free BCD digits decrement: units 0 becomes 9 with tens − 1, otherwise units − 1.
  - `dec & ~inc & ~empty`: `count − 1`. Free BCD digits increment: units 9 becomes 0 with tens + 1, otherwise units + 1.
  - `inc & ~dec & full`: count and digits hold, `ovf` = 1 for one cycle.
  - `dec & ~inc & empty`: count and digits hold, `unf` = 1 for one cycle.
  - `inc & dec` in the same cycle: net zero. Count and digits hold, no error pulse, regardless of full/empty.
  - No event: everything holds.
- **Flags.** `full` and `empty` are registered and recomputed from the next-state count. They always agree with `count` in the same cycle.
- **BCD digits** are maintained incrementally, not by division. The invariant `free_tens*10 + free_units == CAPACITY - count` holds every cycle.
- **Reset** (async, immediate on `rst` high):
  - `count` = 0, `empty` = 1, `full` = 0, `ovf` = `unf` = 0.
  - Free digits = BCD of `CAPACITY` (default 5 and 0).
  - All synchronizer and edge flops cleared.
- **Reset mid-operation.** A pulse in flight is discarded. If `S` or `R` is still high when `rst` releases, it is counted once, after the synchronizer fills.

## Timing

- Let `S` go high before rising edge k. Then:
  - `s_sync` is 1 after edge k+1.
  - `inc` is high during cycle k+1.
  - `count`, digits and flags change at edge k+2.
  - Input-to-output latency is 2 clock edges; `ovf`/`unf` have the same latency.
- `ovf`/`unf` are high for exactly one cycle per offending event.
- Minimum spacing between events on one input: `S` low for ≥ 2 consecutive cycles so the synchronizer sees a 0; otherwise two entries merge into one.
- `S` and `R` are processed independently. Their edges landing in the same cycle is the simultaneous case above.
- No combinational path from any input to any output.

## Test plan

- **Reset.** Assert `rst` asynchronously mid-cycle → `count`=0, `empty`=1, `full`=0, `free_tens`=5, `free_units`=0, `ovf`=`unf`=0 immediately, without waiting for a clock edge.
- **Single entry, held level.** `S` held high 5 cycles → `count` 0→1 exactly 2 edges after first sampling, and only once; `empty` falls; free digits 5/0→4/9.
- **Fill to capacity.** 50 separated `S` pulses → `count`=50, `full`=1, digits 0/0. 51st pulse → `count` stays 50, one-cycle `ovf`.
- **Drain and underflow.** From 3 cars, 4 `R` pulses → count 2, 1, 0, then a single `unf`; digits end at 5/0; `empty`=1.
- **Simultaneous events.** `S` and `R` rise in the same cycle at `count`=50 → no change, no `ovf`; repeat at `count`=0 → no change, no `unf`.
- **BCD borrow/carry and mid-operation reset.** Enter from 40 to 41 → digits 1/0→0/9. Exit from 41 to 40 → digits 0/9→1/0. Assert `rst` one cycle after `S` rises → `count` remains 0 until `rst` releases; `S` still high afterwards is counted exactly once.
